// File: rtl/synth_cfg_pkg.sv
// Shared opcodes, FSM encoding and reset configuration for the synth config sequencer.
package synth_cfg_pkg;

  localparam int unsigned CFG_BYTES = 6;
  localparam int unsigned CFG_W     = 8 * CFG_BYTES;

  // saw/osc: oct 3 period 56; damp: oct 4 period 56
  localparam logic [CFG_W-1:0] CFG_RESET = 48'h0838_0638_0638;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_WAIT   = 2'b10;
  localparam logic [1:0] OP_CLRERR = 2'b11;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_DATA    = 3'd1,
    ST_WARG    = 3'd2,
    ST_WAITING = 3'd3,
    ST_CMT     = 3'd4
  } state_e;

endpackage

// File: rtl/synth_cfg_sequencer_frame_wait_counter.sv
// Counts frame_sync pulses down from a loaded value; done marks the terminal pulse.
module frame_wait_counter #(
  parameter int unsigned WAIT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WAIT_BITS-1:0] n,
  input  logic                 frame_sync,
  output logic                 done
);

  logic [WAIT_BITS-1:0] count_q;
  logic [WAIT_BITS-1:0] count_d;

  // A load cycle swallows any coincident frame_sync.
  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (load) begin
      count_d = n;
    end else if (frame_sync && (count_q != '0)) begin
      count_d = count_q - WAIT_BITS'(1);
      done    = (count_q == WAIT_BITS'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/synth_cfg_sequencer.sv
// Parses a byte stream into shadow writes, frame-aligned atomic commits and frame waits.
module synth_cfg_sequencer
  import synth_cfg_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 6,
  parameter int unsigned WAIT_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   frame_sync,
  output logic [8*NUM_BYTES-1:0] cfg,
  output logic                   commit_pending,
  output logic                   err
);

  localparam int unsigned SEQ_W = 8 * NUM_BYTES;
  localparam logic [SEQ_W-1:0] CFG_INIT = SEQ_W'(CFG_RESET);

  state_e           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [SEQ_W-1:0] shadow_q, shadow_d;
  logic [SEQ_W-1:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             commit_pending_q, commit_pending_d;

  logic             accept_c;
  logic             wait_load_c;
  logic             wait_done_c;
  logic [1:0]       opcode_c;

  assign accept_c = in_valid & in_ready_q;
  assign opcode_c = in_data[7:6];

  frame_wait_counter #(
    .WAIT_BITS (WAIT_BITS)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (wait_load_c),
    .n          (WAIT_BITS'(in_data)),
    .frame_sync (frame_sync),
    .done       (wait_done_c)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    err_d       = err_q;
    wait_load_c = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (accept_c) begin
          if (opcode_c == OP_WRITE) begin
            addr_d  = in_data[2:0];
            state_d = ST_DATA;
          end else if (opcode_c == OP_COMMIT) begin
            state_d = ST_CMT;
          end else if (opcode_c == OP_WAIT) begin
            state_d = ST_WARG;
          end else begin
            err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          if (32'(addr_q) < NUM_BYTES) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
              if (addr_q == 3'(i)) begin
                shadow_d[8*i +: 8] = in_data;
              end
            end
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_HDR;
        end
      end
      ST_WARG: begin
        if (accept_c) begin
          wait_load_c = 1'b1;
          state_d     = (in_data == 8'd0) ? ST_HDR : ST_WAITING;
        end
      end
      ST_WAITING: begin
        if (wait_done_c) begin
          state_d = ST_HDR;
        end
      end
      ST_CMT: begin
        // Whole-word copy in one edge keeps the synth core from seeing partial updates.
        if (frame_sync) begin
          cfg_d   = shadow_q;
          state_d = ST_HDR;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase

    in_ready_d       = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_WARG);
    commit_pending_d = (state_d == ST_CMT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_HDR;
      addr_q           <= 3'd0;
      shadow_q         <= CFG_INIT;
      cfg_q            <= CFG_INIT;
      err_q            <= 1'b0;
      in_ready_q       <= 1'b1;
      commit_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      shadow_q         <= shadow_d;
      cfg_q            <= cfg_d;
      err_q            <= err_d;
      in_ready_q       <= in_ready_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign cfg            = cfg_q;
  assign commit_pending = commit_pending_q;
  assign err            = err_q;

endmodule

// File: tb/tb_synth_cfg_sequencer.sv
// Directed and randomized bench for synth_cfg_sequencer against a command-level reference model.
module tb_synth_cfg_sequencer;

  localparam logic [47:0] RST_CFG = 48'h0838_0638_0638;
  localparam int ARG_NONE = -1;
  localparam int ARG_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        frame_sync;
  logic [47:0] cfg;
  logic        commit_pending;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs_mode  = 0;  // 0: no frame_sync, 1: every 4th cycle, 2: random

  // Reference model: pending argument slot, frames left to stall, commit-on-release flag
  logic [47:0] m_shadow, m_cfg;
  logic        m_err;
  int          m_arg;
  int          m_stall;
  bit          m_commit;
  bit          last_fs;

  synth_cfg_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .frame_sync     (frame_sync),
    .cfg            (cfg),
    .commit_pending (commit_pending),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = RST_CFG;
    m_cfg    = RST_CFG;
    m_err    = 1'b0;
    m_arg    = ARG_NONE;
    m_stall  = 0;
    m_commit = 1'b0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".in_ready"}, 64'(in_ready), 64'(m_stall == 0));
    check({ctx, ".cfg"}, 64'(cfg), 64'(m_cfg));
    check({ctx, ".err"}, 64'(err), 64'(m_err));
    check({ctx, ".commit_pending"}, 64'(commit_pending), 64'(m_commit && m_stall > 0));
  endtask

  // One clock: drive, advance the model across the edge, then compare after the edge.
  task automatic step(input bit valid, input logic [7:0] data, output bit acc);
    bit fs;
    case (fs_mode)
      1:       fs = (cyc % 4 == 0);
      2:       fs = ($urandom_range(0, 3) == 0);
      default: fs = 1'b0;
    endcase
    in_valid   = valid;
    in_data    = data;
    frame_sync = fs;
    last_fs    = fs;
    acc        = valid && (m_stall == 0);
    if (m_stall > 0) begin
      if (fs) begin
        m_stall--;
        if (m_stall == 0 && m_commit) begin
          m_cfg    = m_shadow;
          m_commit = 1'b0;
        end
      end
    end else if (acc) begin
      if (m_arg == ARG_NONE) begin
        case (data[7:6])
          2'b00:   m_arg = int'(data[2:0]);
          2'b01:   begin m_stall = 1; m_commit = 1'b1; end
          2'b10:   m_arg = ARG_WAIT;
          default: m_err = 1'b0;
        endcase
      end else if (m_arg == ARG_WAIT) begin
        m_stall = int'(data);
        m_arg   = ARG_NONE;
      end else begin
        if (m_arg < 6) m_shadow[8*m_arg +: 8] = data;
        else           m_err = 1'b1;
        m_arg = ARG_NONE;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), a);
  endtask

  // Hold a byte valid until accepted, bounded.
  task automatic send(input logic [7:0] b);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 600 && !a; i++) step(1'b1, b, a);
    if (!a) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted byte=%0h", b);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h40;
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    check_outputs("reset");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && m_stall > 0; i++) idle(1);
  endtask

  initial begin
    int fs_seen;
    bit a;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    frame_sync = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("reset_cfg_const", 64'(cfg), 64'(48'h0838_0638_0638));

    // WRITE, WRITE, COMMIT, then a WRITE header held valid through the commit stall
    fs_mode = 1;
    send(8'h00); send(8'hAB);
    send(8'h05); send(8'hCD);
    check("shadow_not_live", 64'(cfg), 64'(RST_CFG));
    send(8'h40);
    check("commit_pending_after_accept", 64'(commit_pending), 64'(1));
    send(8'h00);
    check("commit_cfg_const", 64'(cfg), 64'(48'hCD38_0638_06AB));
    send(8'hAB);

    // WAIT 3: ready returns the cycle after the third counted frame_sync
    send(8'h80);
    send(8'h03);
    fs_seen = 0;
    for (int i = 0; i < 100 && !in_ready; i++) begin
      step(1'b0, 8'h00, a);
      if (last_fs) fs_seen++;
    end
    check("wait3_frames", 64'(fs_seen), 64'(3));
    send(8'h80);
    send(8'h00);
    check("wait0_no_stall", 64'(in_ready), 64'(1));

    // Bad address sets err; commit then publishes the untouched reset shadow
    do_reset();
    send(8'h07); send(8'h55);
    check("err_set", 64'(err), 64'(1));
    send(8'h40);
    wait_idle();
    check("err_commit_cfg", 64'(cfg), 64'(RST_CFG));
    send(8'hC0);
    check("err_cleared", 64'(err), 64'(0));

    // Reset while a commit is pending drops it
    fs_mode = 0;
    send(8'h05); send(8'h11);
    send(8'h40);
    idle(2);
    check("pending_before_reset", 64'(commit_pending), 64'(1));
    do_reset();
    fs_mode = 1;
    idle(8);
    check("reset_drop_cfg", 64'(cfg), 64'(RST_CFG));
    check("reset_drop_ready", 64'(in_ready), 64'(1));

    // Randomized command stream with random gaps and random frame_sync
    fs_mode = 2;
    for (int k = 0; k < 300; k++) begin
      logic [1:0] op;
      logic [7:0] hdr;
      op  = 2'($urandom_range(0, 3));
      hdr = {op, 3'($urandom), 3'($urandom_range(0, 7))};
      idle(int'($urandom_range(0, 2)));
      send(hdr);
      if (op == 2'b00) send(8'($urandom));
      else if (op == 2'b10) send(8'($urandom_range(0, 5)));
    end
    wait_idle();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
